// File: rtl/mem_block_engine.sv
// mem_block_engine
//   Bus initiator for a single-port word memory with a one-cycle registered read.
//   A start request either fills a destination range with a constant or copies a
//   source range to a destination range, one word at a time, while this block
//   drives the memory strobes. While busy it is the only master of the memory port.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   start       operation request, sampled only when idle
//   mode        0 = copy src -> dst, 1 = fill dst with fill_data
//   src, dst    base word addresses; only the low ADDR_BITS bits are used
//   len         word count (0 is legal, values above 2**ADDR_BITS are clamped)
//   fill_data   fill pattern
//   busy        operation in progress
//   done        one-cycle completion pulse
//   word_count  words written by the current or last operation
//   ram_cs      memory chip select
//   ram_rw      memory write enable (1 = write)
//   ram_addr    memory word address (upper bits above ADDR_BITS held at 0)
//   ram_wdata   memory write data
//   ram_rdata   memory read data, valid the cycle after a read strobe
//
// All outputs are decoded from registers only.

module mem_block_engine #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned LEN_BITS   = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [15:0]           src,
  input  logic [15:0]           dst,
  input  logic [LEN_BITS-1:0]   len,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_BITS-1:0]   word_count,
  output logic                  ram_cs,
  output logic                  ram_rw,
  output logic [15:0]           ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFillWr = 3'd1;
  localparam logic [2:0] StCpRd   = 3'd2;
  localparam logic [2:0] StCpLat  = 3'd3;
  localparam logic [2:0] StCpWr   = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  localparam logic [LEN_BITS-1:0] MaxLen = LEN_BITS'(1 << ADDR_BITS);

  logic [2:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  src_q, src_d;
  logic [ADDR_BITS-1:0]  dst_q, dst_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   idx_q, idx_d;
  logic [LEN_BITS-1:0]   count_q, count_d;
  // Holds fill_data for fills and the word in flight for copies.
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [LEN_BITS-1:0]   len_clamped;
  logic                  last_word;
  logic [ADDR_BITS-1:0]  src_addr;
  logic [ADDR_BITS-1:0]  dst_addr;

  // Address bits above ADDR_BITS are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src[15:ADDR_BITS], dst[15:ADDR_BITS]};

  assign len_clamped = (len > MaxLen) ? MaxLen : len;
  assign last_word   = (idx_q + LEN_BITS'(1)) == len_q;

  // Base plus index truncated to ADDR_BITS, so ranges wrap around the memory.
  assign src_addr = src_q + idx_q[ADDR_BITS-1:0];
  assign dst_addr = dst_q + idx_q[ADDR_BITS-1:0];

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    count_d = count_q;
    data_d  = data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src[ADDR_BITS-1:0];
          dst_d   = dst[ADDR_BITS-1:0];
          len_d   = len_clamped;
          idx_d   = '0;
          count_d = '0;
          if (mode) begin
            data_d = fill_data;
          end
          if (len == '0) begin
            state_d = StDone;
          end else if (mode) begin
            state_d = StFillWr;
          end else begin
            state_d = StCpRd;
          end
        end
      end

      StFillWr: begin
        idx_d   = idx_q + LEN_BITS'(1);
        count_d = count_q + LEN_BITS'(1);
        if (last_word) begin
          state_d = StDone;
        end
      end

      StCpRd: begin
        state_d = StCpLat;
      end

      StCpLat: begin
        // The memory presents the word read in StCpRd during this cycle.
        data_d  = ram_rdata;
        state_d = StCpWr;
      end

      StCpWr: begin
        idx_d   = idx_q + LEN_BITS'(1);
        count_d = count_q + LEN_BITS'(1);
        state_d = last_word ? StDone : StCpRd;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  // Moore output decode; reset forces StIdle, which drops every strobe at once.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ram_cs   = 1'b0;
    ram_rw   = 1'b0;
    ram_addr = '0;

    case (state_q)
      StFillWr: begin
        busy                    = 1'b1;
        ram_cs                  = 1'b1;
        ram_rw                  = 1'b1;
        ram_addr[ADDR_BITS-1:0] = dst_addr;
      end
      StCpRd: begin
        busy                    = 1'b1;
        ram_cs                  = 1'b1;
        ram_addr[ADDR_BITS-1:0] = src_addr;
      end
      StCpLat: begin
        busy                    = 1'b1;
        ram_addr[ADDR_BITS-1:0] = src_addr;
      end
      StCpWr: begin
        busy                    = 1'b1;
        ram_cs                  = 1'b1;
        ram_rw                  = 1'b1;
        ram_addr[ADDR_BITS-1:0] = dst_addr;
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign word_count = count_q;
  assign ram_wdata  = data_q;

endmodule

// File: tb/tb_mem_block_engine.sv
// Testbench for mem_block_engine: behavioural memory, a reference model that
// expands each operation into its expected access list, and a monitor that
// pops and compares those expectations whenever the DUT strobes the memory
// or pulses done.

module tb_mem_block_engine;

  localparam int unsigned DW = 16;
  localparam int unsigned AB = 12;
  localparam int unsigned LB = 13;
  localparam int MemWords = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [15:0]   src = '0;
  logic [15:0]   dst = '0;
  logic [LB-1:0] len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          busy;
  logic          done;
  logic [LB-1:0] word_count;
  logic          ram_cs;
  logic          ram_rw;
  logic [15:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] ram    [MemWords];
  logic [DW-1:0] shadow [MemWords];

  typedef struct {
    bit            rw;
    int            addr;
    logic [DW-1:0] data;
  } acc_t;

  typedef struct {
    int wc;
    int busy_cycles;
  } fin_t;

  acc_t exp_acc[$];
  fin_t exp_fin[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_block_engine #(
    .DATA_WIDTH(DW),
    .ADDR_BITS (AB),
    .LEN_BITS  (LB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Single-port memory with registered read.
  initial begin
    ram_rdata = '0;
    for (int i = 0; i < MemWords; i++) ram[i] = DW'($urandom);
    forever begin
      @(posedge clk);
      if (ram_cs) begin
        if (ram_rw) ram[ram_addr[AB-1:0]] <= ram_wdata;
        else        ram_rdata <= ram[ram_addr[AB-1:0]];
      end
    end
  end

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: expand an operation into its ordered list of memory accesses.
  task automatic model_op(bit m, logic [15:0] s, logic [15:0] d, int l, logic [DW-1:0] f);
    int   n;
    int   sa;
    int   da;
    acc_t a;
    fin_t fe;
    n = (l > MemWords) ? MemWords : l;
    for (int i = 0; i < n; i++) begin
      sa = (int'(s) + i) % MemWords;
      da = (int'(d) + i) % MemWords;
      if (m) begin
        a.rw = 1'b1; a.addr = da; a.data = f;
        exp_acc.push_back(a);
        shadow[da] = f;
      end else begin
        a.rw = 1'b0; a.addr = sa; a.data = '0;
        exp_acc.push_back(a);
        a.rw = 1'b1; a.addr = da; a.data = shadow[sa];
        exp_acc.push_back(a);
        shadow[da] = shadow[sa];
      end
    end
    fe.wc = n;
    fe.busy_cycles = m ? n : 3 * n;
    exp_fin.push_back(fe);
  endtask

  task automatic scramble();
    mode      = 1'($urandom);
    src       = 16'($urandom);
    dst       = 16'($urandom);
    len       = LB'($urandom);
    fill_data = DW'($urandom);
  endtask

  // Issue one operation and wait (bounded) for its done pulse. With junk set,
  // stray start pulses are driven during the run and in the done cycle.
  task automatic run_op(bit m, logic [15:0] s, logic [15:0] d, int l, logic [DW-1:0] f,
                        bit junk);
    int n;
    int budget;
    bit seen;
    @(negedge clk);
    mode = m; src = s; dst = d; len = LB'(l); fill_data = f; start = 1'b1;
    model_op(m, s, d, l, f);
    n = (l > MemWords) ? MemWords : l;
    budget = 3 * n + 8;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    scramble();
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = junk && (c == 1 || c == 3);
      if (start) scramble();
      @(negedge clk);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles (mode=%0d len=%0d)", budget, m, l);
      start = 1'b0;
    end else if (junk) begin
      start = 1'b1;
      scramble();
    end else begin
      start = 1'b0;
    end
  endtask

  // Monitor: compare every strobe and done pulse against the expectation queues.
  initial begin
    acc_t e;
    fin_t f;
    int   busy_cnt;
    bit   prev_done;
    busy_cnt = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
        prev_done = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        check("rw_implies_cs", int'(ram_rw & ~ram_cs), 0);
        if (ram_cs) begin
          if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: rw=%0d addr=0x%0h, expected none", ram_rw,
                     ram_addr);
          end else begin
            e = exp_acc.pop_front();
            check("access_rw", int'(ram_rw), int'(e.rw));
            check("access_addr", int'(ram_addr), e.addr);
            if (e.rw) check("access_wdata", int'(ram_wdata), int'(e.data));
          end
        end
        if (done) begin
          check("done_one_cycle", int'(prev_done), 0);
          check("done_not_busy", int'(busy), 0);
          if (exp_fin.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done, expected none");
          end else begin
            f = exp_fin.pop_front();
            check("word_count", int'(word_count), f.wc);
            check("busy_cycles", busy_cnt, f.busy_cycles);
            check("accesses_left_at_done", exp_acc.size(), 0);
          end
          busy_cnt = 0;
        end
        prev_done = done;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    bit m;
    logic [15:0] s;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_cs", int'(ram_cs), 0);
    check("reset_rw", int'(ram_rw), 0);
    check("reset_addr", int'(ram_addr), 0);
    check("reset_wdata", int'(ram_wdata), 0);
    check("reset_word_count", int'(word_count), 0);
    rst = 1'b0;
    for (int i = 0; i < MemWords; i++) shadow[i] = ram[i];

    // Directed fill
    run_op(1'b1, 16'h0000, 16'h0010, 4, 16'hABCD, 1'b0);
    for (int k = 0; k < 4; k++) check("fill_readback", int'(ram[16 + k]), 'hABCD);

    // Seed 1,2,3 then copy with stray starts during the run and in the done cycle
    run_op(1'b1, 16'h0, 16'h0100, 1, 16'd1, 1'b0);
    run_op(1'b1, 16'h0, 16'h0101, 1, 16'd2, 1'b0);
    run_op(1'b1, 16'h0, 16'h0102, 1, 16'd3, 1'b0);
    run_op(1'b0, 16'h0100, 16'h0200, 3, 16'h0, 1'b1);
    for (int k = 0; k < 3; k++) check("copy_readback", int'(ram['h200 + k]), k + 1);

    // Start on the cycle right after done is accepted; zero length
    run_op(1'b1, 16'h0, 16'h0777, 0, 16'h1234, 1'b0);
    run_op(1'b1, 16'h0, 16'h0050, 2, 16'h00FF, 1'b0);

    // Wrap and overlapping forward copy
    run_op(1'b1, 16'h0, 16'h0FFE, 4, 16'h5A5A, 1'b0);
    check("wrap_ffe", int'(ram['hFFE]), 'h5A5A);
    check("wrap_fff", int'(ram['hFFF]), 'h5A5A);
    check("wrap_000", int'(ram[0]), 'h5A5A);
    check("wrap_001", int'(ram[1]), 'h5A5A);
    run_op(1'b0, 16'h0400, 16'h0401, 5, 16'h0, 1'b0);
    for (int k = 0; k < 6; k++) check("overlap_replicate", int'(ram['h400 + k]),
                                      int'(shadow['h400]));

    // Randomised operations, upper address bits random
    for (int r = 0; r < 14; r++) begin
      m = 1'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
      s = 16'($urandom);
      if (r % 4 == 3) s[11:0] = 12'hFFC;
      run_op(m, s, 16'($urandom), l, DW'($urandom), !m && l >= 2 && 1'($urandom));
    end

    // Reset mid-fill
    @(negedge clk);
    mode = 1'b1; src = '0; dst = 16'h0300; len = LB'(20); fill_data = 16'hC0DE; start = 1'b1;
    model_op(1'b1, 16'h0, 16'h0300, 20, 16'hC0DE);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_cs", int'(ram_cs), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_word_count", int'(word_count), 0);
    exp_acc.delete();
    exp_fin.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle_cs", int'(ram_cs), 0);
    check("post_reset_idle_busy", int'(busy), 0);
    check("post_reset_idle_done", int'(done), 0);
    // Writes issued before the reset were each checked by the monitor.
    for (int i = 0; i < MemWords; i++) shadow[i] = ram[i];

    run_op(1'b0, 16'h0300, 16'h0500, 4, 16'h0, 1'b0);

    // Length above the memory size is clamped
    run_op(1'b1, 16'h0, 16'hF123, 5000, 16'h0F0F, 1'b0);
    run_op(1'b0, 16'h0120, 16'h0800, 6, 16'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty_acc", exp_acc.size(), 0);
    check("queue_empty_fin", exp_fin.size(), 0);
    begin
      int bad;
      bad = -1;
      for (int i = 0; i < MemWords; i++) if (bad < 0 && ram[i] !== shadow[i]) bad = i;
      if (bad >= 0)
        $display("FAIL memory_image: word 0x%0h got 0x%0h, expected 0x%0h", bad, ram[bad],
                 shadow[bad]);
      checks++;
      if (bad >= 0) errors++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
